// File: rtl/fft_tile_mac.sv
// -----------------------------------------------------------------------------
// fft_tile_mac
//
// Element-wise complex multiply-accumulate of 4x4 spectral tiles. Each in_next
// pulse delivers one FFT output tile and the matching kernel-spectrum tile.
// The 16 complex products are summed over num_ch consecutive input channels.
// Each finished sum is written as one 1024-bit word to the output image memory.
//
// Number format: signed Q16.16 per 32-bit component. Element k = 4*row+col sits
// in bits [64k+63:64k], with the real part in the upper 32 bits.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle job start, samples num_ch/num_tiles/base_addr
//   num_ch     : channels summed per output tile (0 behaves as 1)
//   num_tiles  : output tiles per job (0 behaves as 1)
//   base_addr  : output address of the first tile
//   in_next    : in_tile/kern_tile valid strobe
//   in_tile    : 16 complex FFT elements
//   kern_tile  : 16 complex kernel elements
//   out_we     : one-cycle write strobe per finished tile
//   out_addr   : write address (base_addr + tile index, wrapping)
//   out_data   : accumulated tile; holds its value between writes
//   busy       : job in progress
//   done       : pulses together with the last write of a job
//
// Latency from in_next to out_we is two cycles: products are registered first,
// then the accumulate/write stage runs.
// -----------------------------------------------------------------------------
module fft_tile_mac #(
    parameter int CH_W       = 8,
    parameter int TILE_W     = 10,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CH_W-1:0]       num_ch,
    input  logic [TILE_W-1:0]     num_tiles,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_next,
    input  logic [1023:0]         in_tile,
    input  logic [1023:0]         kern_tile,
    output logic                  out_we,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [1023:0]         out_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1'b1);
    localparam logic [CH_W-1:0]   CH_ZERO   = {CH_W{1'b0}};
    localparam logic [TILE_W-1:0] TILE_ONE  = TILE_W'(1'b1);
    localparam logic [TILE_W-1:0] TILE_ZERO = {TILE_W{1'b0}};

    // Q16.16 complex multiply. The 64-bit intermediates wrap, and the shifted
    // result is truncated to 32 bits with no saturation.
    function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] ar;
        logic signed [63:0] ai;
        logic signed [63:0] br;
        logic signed [63:0] bi;
        logic signed [63:0] re;
        logic signed [63:0] im;
        ar = {{32{a[63]}}, a[63:32]};
        ai = {{32{a[31]}}, a[31:0]};
        br = {{32{b[63]}}, b[63:32]};
        bi = {{32{b[31]}}, b[31:0]};
        re = (ar * br) - (ai * bi);
        im = (ar * bi) + (ai * br);
        return {32'(re >>> 16), 32'(im >>> 16)};
    endfunction

    // Component-wise 32-bit wrapping complex add.
    function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b);
        return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
    endfunction

    // Control state
    state_e                state_q,     state_d;
    logic [CH_W-1:0]       num_ch_q,    num_ch_d;
    logic [TILE_W-1:0]     num_tiles_q, num_tiles_d;
    logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;

    // Input-side counters. These decide which in_next pulses still belong to the job.
    logic [CH_W-1:0]       in_ch_q,     in_ch_d;
    logic [TILE_W-1:0]     in_tile_q,   in_tile_d;
    logic                  in_last_q,   in_last_d;

    // Stage 1: registered products
    logic                  s1_valid_q,  s1_valid_d;
    logic [1023:0]         prod_q,      prod_d;

    // Stage 2: accumulation and its counters
    logic [CH_W-1:0]       chan_cnt_q,  chan_cnt_d;
    logic [TILE_W-1:0]     tile_cnt_q,  tile_cnt_d;
    logic [1023:0]         acc_q,       acc_d;

    // Registered outputs
    logic                  out_we_q,    out_we_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [1023:0]         out_data_q,  out_data_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    // Combinational datapath
    logic [1023:0]         prod_s;
    logic [1023:0]         sum_s;
    logic                  ch_first_s;
    logic                  ch_last_s;

    // Products of the incoming tile pair, and the next accumulator value.
    always_comb begin
        prod_s     = {1024{1'b0}};
        sum_s      = {1024{1'b0}};
        ch_first_s = (chan_cnt_q == CH_ZERO);
        ch_last_s  = (chan_cnt_q == (num_ch_q - CH_ONE));
        for (int k = 0; k < 16; k++) begin
            prod_s[64*k +: 64] = cmul(in_tile[64*k +: 64], kern_tile[64*k +: 64]);
            if (ch_first_s) begin
                sum_s[64*k +: 64] = prod_q[64*k +: 64];
            end else begin
                sum_s[64*k +: 64] = cadd(acc_q[64*k +: 64], prod_q[64*k +: 64]);
            end
        end
    end

    // Next-state logic for the FSM, counters, pipeline and outputs.
    always_comb begin
        state_d     = state_q;
        num_ch_d    = num_ch_q;
        num_tiles_d = num_tiles_q;
        base_addr_d = base_addr_q;
        in_ch_d     = in_ch_q;
        in_tile_d   = in_tile_q;
        in_last_d   = in_last_q;
        s1_valid_d  = 1'b0;
        prod_d      = prod_q;
        chan_cnt_d  = chan_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        acc_d       = acc_q;
        out_we_d    = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_ch_d    = (num_ch == CH_ZERO) ? CH_ONE : num_ch;
                    num_tiles_d = (num_tiles == TILE_ZERO) ? TILE_ONE : num_tiles;
                    base_addr_d = base_addr;
                    in_ch_d     = CH_ZERO;
                    in_tile_d   = TILE_ZERO;
                    in_last_d   = 1'b0;
                    chan_cnt_d  = CH_ZERO;
                    tile_cnt_d  = TILE_ZERO;
                    acc_d       = {1024{1'b0}};
                    state_d     = ST_ACCUM;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                // The done cycle is the final ACCUM cycle. busy drops one cycle after done.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCUM;
                end

                // Once the job's last input has entered the pipe, later in_next pulses are dropped.
                if (in_next && !in_last_q) begin
                    s1_valid_d = 1'b1;
                    prod_d     = prod_s;
                    if (in_ch_q == (num_ch_q - CH_ONE)) begin
                        in_ch_d = CH_ZERO;
                        if (in_tile_q == (num_tiles_q - TILE_ONE)) begin
                            in_last_d = 1'b1;
                        end else begin
                            in_tile_d = in_tile_q + TILE_ONE;
                        end
                    end else begin
                        in_ch_d = in_ch_q + CH_ONE;
                    end
                end else begin
                    s1_valid_d = 1'b0;
                end

                // Accumulate stage. Write the tile out once its last channel arrives.
                if (s1_valid_q) begin
                    acc_d = sum_s;
                    if (ch_last_s) begin
                        chan_cnt_d = CH_ZERO;
                        tile_cnt_d = tile_cnt_q + TILE_ONE;
                        out_we_d   = 1'b1;
                        out_data_d = sum_s;
                        out_addr_d = base_addr_q + ADDR_WIDTH'(tile_cnt_q);
                        done_d     = (tile_cnt_q == (num_tiles_q - TILE_ONE));
                    end else begin
                        chan_cnt_d = chan_cnt_q + CH_ONE;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCUM);
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            num_ch_q    <= CH_ONE;
            num_tiles_q <= TILE_ONE;
            base_addr_q <= {ADDR_WIDTH{1'b0}};
            in_ch_q     <= CH_ZERO;
            in_tile_q   <= TILE_ZERO;
            in_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            prod_q      <= {1024{1'b0}};
            chan_cnt_q  <= CH_ZERO;
            tile_cnt_q  <= TILE_ZERO;
            acc_q       <= {1024{1'b0}};
            out_we_q    <= 1'b0;
            out_addr_q  <= {ADDR_WIDTH{1'b0}};
            out_data_q  <= {1024{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            num_tiles_q <= num_tiles_d;
            base_addr_q <= base_addr_d;
            in_ch_q     <= in_ch_d;
            in_tile_q   <= in_tile_d;
            in_last_q   <= in_last_d;
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            chan_cnt_q  <= chan_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            acc_q       <= acc_d;
            out_we_q    <= out_we_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fft_tile_mac.sv
// -----------------------------------------------------------------------------
// Testbench for fft_tile_mac.
// A job-level reference model counts the in_next pulses accepted in a job.
// It forms Q16.16 products and running channel sums with integer arithmetic.
// It queues each expected memory write together with the cycle in which the
// write should appear. DUT outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fft_tile_mac;

    localparam int CH_W   = 8;
    localparam int TILE_W = 10;
    localparam int AW     = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CH_W-1:0]   num_ch;
    logic [TILE_W-1:0] num_tiles;
    logic [AW-1:0]     base_addr;
    logic              in_next;
    logic [1023:0]     in_tile;
    logic [1023:0]     kern_tile;
    logic              out_we;
    logic [AW-1:0]     out_addr;
    logic [1023:0]     out_data;
    logic              busy;
    logic              done;

    fft_tile_mac #(.CH_W(CH_W), .TILE_W(TILE_W), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_ch    (num_ch),
        .num_tiles (num_tiles),
        .base_addr (base_addr),
        .in_next   (in_next),
        .in_tile   (in_tile),
        .kern_tile (kern_tile),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [1023:0] data;
        bit            last;
    } wr_t;

    wr_t           sb[$];
    bit            job_on;
    int            job_start_c;
    int            job_end_c;
    int            m_ch;
    int            m_tiles;
    int            m_total;
    int            m_cnt;
    logic [AW-1:0] m_base;
    int            acc_re[16];
    int            acc_im[16];
    logic [AW-1:0] last_addr;
    logic [1023:0] last_data;

    // Q16.16 complex product: 64-bit math, arithmetic shift right by 16, low 32 bits kept
    function automatic logic [63:0] m_mul(input logic [63:0] a, input logic [63:0] b);
        longint ar, ai, br, bi, re, im;
        ar = longint'($signed(a[63:32]));
        ai = longint'($signed(a[31:0]));
        br = longint'($signed(b[63:32]));
        bi = longint'($signed(b[31:0]));
        re = (ar * br - ai * bi) >>> 16;
        im = (ar * bi + ai * br) >>> 16;
        return {re[31:0], im[31:0]};
    endfunction

    // The job occupies the block from the cycle after start until the done cycle, inclusive.
    function automatic bit m_accum(input int c);
        return job_on && (c >= job_start_c + 1) && (c <= job_end_c);
    endfunction

    task automatic model_edge(input int c);
        bit          active;
        int          chpos;
        int          tl;
        logic [63:0] p;
        wr_t         w;
        active = m_accum(c);
        if (!active) begin
            if (start) begin
                job_on      = 1'b1;
                job_start_c = c;
                job_end_c   = 32'h7FFF_FFFF;
                m_ch        = (num_ch == '0) ? 1 : int'(num_ch);
                m_tiles     = (num_tiles == '0) ? 1 : int'(num_tiles);
                m_total     = m_ch * m_tiles;
                m_cnt       = 0;
                m_base      = base_addr;
            end
        end else if (in_next && (m_cnt < m_total)) begin
            chpos = m_cnt % m_ch;
            tl    = m_cnt / m_ch;
            for (int k = 0; k < 16; k++) begin
                p = m_mul(in_tile[64*k +: 64], kern_tile[64*k +: 64]);
                if (chpos == 0) begin
                    acc_re[k] = int'(p[63:32]);
                    acc_im[k] = int'(p[31:0]);
                end else begin
                    acc_re[k] = acc_re[k] + int'(p[63:32]);
                    acc_im[k] = acc_im[k] + int'(p[31:0]);
                end
            end
            m_cnt++;
            if (chpos == m_ch - 1) begin
                w.due  = c + 2;
                w.addr = m_base + AW'(tl);
                for (int k = 0; k < 16; k++) w.data[64*k +: 64] = {acc_re[k], acc_im[k]};
                w.last = (m_cnt == m_total);
                if (w.last) job_end_c = c + 2;
                sb.push_back(w);
            end
        end
    endtask

    task automatic check_outputs(input int c);
        bit  exp_we;
        bit  exp_done;
        wr_t w;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
            if (sb[0].due <= c) begin
                w         = sb.pop_front();
                exp_we    = 1'b1;
                exp_done  = w.last;
                last_addr = w.addr;
                last_data = w.data;
            end
        end
        chk("out_we", 64'(out_we), 64'(exp_we));
        chk("done", 64'(done), 64'(exp_done));
        chk("busy", 64'(busy), 64'(m_accum(c)));
        chk("out_addr", 64'(out_addr), 64'(last_addr));
        for (int k = 0; k < 16; k++)
            chk($sformatf("out_data[%0d]", k), out_data[64*k +: 64], last_data[64*k +: 64]);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, then check at the next falling edge
    task automatic step(input bit st, input bit nx, input logic [1023:0] a, input logic [1023:0] b);
        start     = st;
        in_next   = nx;
        in_tile   = a;
        kern_tile = b;
        model_edge(cyc);
        @(negedge clk);
        check_outputs(cyc);
    endtask

    function automatic logic [1023:0] fill(input logic [63:0] e);
        return {16{e}};
    endfunction

    function automatic logic [1023:0] rnd_tile();
        logic [1023:0] t;
        for (int k = 0; k < 32; k++) t[32*k +: 32] = $urandom();
        return t;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_tile(), rnd_tile());
    endtask

    task automatic cfg(input int ch, input int tiles, input int base);
        num_ch    = CH_W'(ch);
        num_tiles = TILE_W'(tiles);
        base_addr = AW'(base);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 64'(out_we), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_addr"}, 64'(out_addr), 64'd0);
        for (int k = 0; k < 16; k++) chk({tag, "_data"}, out_data[64*k +: 64], 64'd0);
    endtask

    task automatic model_clear();
        job_on    = 1'b0;
        m_cnt     = 0;
        m_total   = 0;
        sb.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    // Watchdog: stop the run if it overshoots its expected length
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bit st;
        reset     = 1'b0;
        start     = 1'b0;
        in_next   = 1'b0;
        in_tile   = '0;
        kern_tile = '0;
        cfg(0, 0, 0);
        model_clear();

        // Outputs while reset is held
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // in_next without start must not cause a write
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_tile(), rnd_tile());

        // Single multiply: (1+j1)*(2+j0) = 2+j2
        cfg(1, 1, 'h10);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, fill(64'h0001_0000_0001_0000), fill(64'h0002_0000_0000_0000));
        idle(3);
        chk("single_data", out_data[63:0], 64'h0002_0000_0002_0000);
        chk("single_addr", 64'(out_addr), 64'h10);

        // Three channels of (1+j0)*(1+j0), back to back
        cfg(3, 1, 'h20);
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, fill(64'h0001_0000_0000_0000), fill(64'h0001_0000_0000_0000));
        idle(3);
        chk("accum_data", out_data[64*5 +: 64], 64'h0003_0000_0000_0000);

        // Negative value: (-1.5)*(2) = -3
        cfg(1, 1, 'h30);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, fill(64'hFFFE_8000_0000_0000), fill(64'h0002_0000_0000_0000));
        idle(3);
        chk("sign_data", out_data[63:0], 64'hFFFD_0000_0000_0000);

        // Accumulation wraps: 0x7FFF0000 + 0x00010000
        cfg(2, 1, 'h31);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, fill(64'h7FFF_0000_0000_0000), fill(64'h0001_0000_0000_0000));
        step(1'b0, 1'b1, fill(64'h0001_0000_0000_0000), fill(64'h0001_0000_0000_0000));
        idle(3);
        chk("wrap_data", out_data[64*15 +: 64], 64'h8000_0000_0000_0000);

        // Address wrap over two tiles. The extra in_next pulses arrive after the last input and are dropped.
        cfg(1, 2, 'h1FFF);
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_tile(), rnd_tile());
        idle(3);
        chk("addrwrap_addr", 64'(out_addr), 64'h0);
        chk("addrwrap_busy", 64'(busy), 64'h0);

        // start during the job is ignored; in_next after done is dropped
        cfg(2, 1, 'h40);
        step(1'b1, 1'b0, '0, '0);
        cfg(1, 3, 'h99);
        step(1'b1, 1'b1, rnd_tile(), rnd_tile());
        step(1'b0, 1'b1, rnd_tile(), rnd_tile());
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_tile(), rnd_tile());
        chk("ignstart_addr", 64'(out_addr), 64'h40);

        // Randomized jobs
        for (int j = 0; j < 14; j++) begin
            budget = 0;
            while (m_accum(cyc) && budget < 50) begin
                idle(1);
                budget++;
            end
            cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom());
            step(1'b1, 1'b0, '0, '0);
            budget = 0;
            while (!((m_cnt >= m_total) && (cyc > job_end_c)) && budget < 300) begin
                st = ($urandom_range(0, 9) == 0);
                if (st) cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom());
                step(st, ($urandom_range(0, 9) < 7), rnd_tile(), rnd_tile());
                budget++;
            end
            chk("job_in_budget", 64'(budget < 300), 64'd1);
            for (int i = 0; i < 3; i++) step(1'b0, 1'(($urandom_range(0, 1))), rnd_tile(), rnd_tile());
        end

        // Reset in the middle of a job: outputs clear at once and the job is dropped
        cfg(2, 3, 'h100);
        step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_tile(), rnd_tile());
        #2 reset = 1'b0;
        #1;
        check_all_zero("midrst");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_tile(), rnd_tile());

        // Recovery after reset
        cfg(1, 1, 'h55);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, rnd_tile(), rnd_tile());
        idle(3);
        chk("recover_addr", 64'(out_addr), 64'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_tile_mac.md
Name: fft_tile_mac

Overview:
- Consumes 4x4 complex spectral tiles produced by the 2D FFT4 stage (one tile per `next_out` pulse).
- Multiplies each tile element-wise by a matching kernel-spectrum tile.
- Accumulates the products across input channels.
- After each group of channels, writes the accumulated 4x4 tile to the output image block memory, one word per tile.
- Sits directly downstream of the 2D FFT and upstream of the inverse-FFT/readback path.

Parameters:
- CH_W, 8, width of the channel-count input.
- TILE_W, 10, width of the tile-count input.
- ADDR_WIDTH, 13, output memory address width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; loads configuration and begins a job.
- num_ch  input  CH_W  channels accumulated per output tile; sampled on start.
- num_tiles  input  TILE_W  output tiles per job; sampled on start.
- base_addr  input  ADDR_WIDTH  first output address; sampled on start.
- in_next  input  1  one-cycle pulse; in_tile/kern_tile valid this cycle (driven from FFT `next_out`).
- in_tile  input  1024  16 complex_t elements; element k=4*row+col occupies bits [64k+63:64k], real part in the upper 32 bits.
- kern_tile  input  1024  kernel spectrum tile, same layout, valid with in_next.
- out_we  output  1  write enable to output block memory.
- out_addr  output  ADDR_WIDTH  write address.
- out_data  output  1024  accumulated tile, same layout as in_tile.
- busy  output  1  high in ACCUM state.
- done  output  1  one-cycle pulse when the last tile of a job is written.

Behaviour:
- Reset (reset=0, asynchronous) state:
  - All outputs 0.
  - State IDLE; accumulators, counters and pipeline valid bits cleared.
  - Reset mid-job abandons the job with no further writes.
- States:
  - IDLE: start=1 latches the configuration, zeroes the channel and tile counters and the accumulators, and moves to ACCUM. in_next is ignored in IDLE.
  - ACCUM: start is ignored. After the write of tile num_tiles-1, return to IDLE and pulse done in the same cycle as that out_we.
- num_ch=0 is treated as 1; num_tiles=0 is treated as 1.
- Arithmetic: signed Q16.16 per 32-bit component.
  - Product real = (ar*br - ai*bi) >>> 16; imag = (ar*bi + ai*br) >>> 16.
  - Compute with 64-bit signed intermediates, arithmetic shift, keep the low 32 bits (wrap, no saturation).
  - Accumulation is 32-bit two's-complement wrap.
- Pipeline, fixed latency 2:
  - Stage 1 (edge after in_next): register the 16 complex products and a valid bit.
  - Stage 2: acc <= (chan_cnt==0 ? prod : acc+prod).
  - When the stage-2 element is the last channel (chan_cnt==num_ch-1):
    - The same cycle's registered outputs present out_we=1, out_data = final sum, out_addr = base_addr + tile_cnt (mod 2^ADDR_WIDTH).
    - chan_cnt resets to 0 and tile_cnt increments.
- in_next may be asserted every cycle back to back; there are no bubbles and no backpressure.
- An in_next arriving while the last tile's products are still in the pipeline, or after done, belongs to no job and is dropped.
- out_we is high for exactly one cycle per output tile; out_data and out_addr hold their last values when out_we=0.
- An address overflow past 2^ADDR_WIDTH-1 wraps to 0.
- busy falls the cycle after done.

Test Plan:
- Reset values: assert reset=0 mid-stream -> all outputs 0 immediately; after release, in_next without start -> no out_we.
- Single multiply: num_ch=1, num_tiles=1, base_addr=0x10. Every in element = 1+j1 (0x00010000 each part), every kern element = 2+j0. -> out_we at in_next+2, out_addr=0x10, every element real=0x00020000 and imag=0x00020000, done in the same cycle.
- Channel accumulation: num_ch=3, all elements (1+j0)*(1+j0), three back-to-back in_next -> exactly one write, every element 0x00030000+j0, two cycles after the third in_next.
- Sign and wrap: element 0 = (-1.5+j0)*(2+j0) -> real 0xFFFD0000. Accumulating 0x7FFF0000 + 0x00010000 -> 0x80000000 (wrap).
- Address wrap and multi-tile: base_addr=0x1FFF, num_tiles=2, num_ch=1 -> writes at 0x1FFF then 0x0000; done only on the second write; busy low the following cycle.
- Ignored events: start pulsed during ACCUM -> configuration unchanged. in_next after done -> no write.
